// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Holds the FSM state encoding, requester IDs and the read-latency ceiling.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } arb_state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

    localparam int RD_LAT_MAX = 7;

endpackage

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one byte-wide RAM between a CPU and a loader port.
// All outputs are registered; the grant pointer flips to the loser after each grant.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [7:0]        ldr_wdata,
    output logic              ldr_ack,
    output logic [7:0]        ldr_rdata,
    output logic              mem_RE_RAM,
    output logic              mem_WE_RAM,
    output logic [ADDR_W-1:0] Data_Dir_RAM,
    output logic [7:0]        Data_RAM,
    input  logic [7:0]        Data_in_RAM,
    output logic              busy
);

    // Out-of-range latencies are clamped so the 3-bit counter never wraps.
    localparam logic [2:0] LAT_C = 3'((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX :
                                      ((RD_LAT < 1) ? 1 : RD_LAT));

    arb_state_e        state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              re_q, re_d;
    logic              wr_q, wr_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              ldr_ack_q, ldr_ack_d;
    logic [7:0]        cpu_rdata_q, cpu_rdata_d;
    logic [7:0]        ldr_rdata_q, ldr_rdata_d;
    logic              busy_q, busy_d;
    logic              win_s;

    // Next-state, grant selection and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        re_d        = 1'b0;
        wr_d        = 1'b0;
        cpu_ack_d   = 1'b0;
        ldr_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        win_s       = REQ_CPU;

        case (state_q)
            IDLE: begin
                if (cpu_req && ldr_req) begin
                    win_s = ptr_q;
                end else if (ldr_req) begin
                    win_s = REQ_LDR;
                end else begin
                    win_s = REQ_CPU;
                end

                if (cpu_req || ldr_req) begin
                    owner_d = win_s;
                    ptr_d   = ~win_s;
                    if (win_s == REQ_LDR) begin
                        we_d    = ldr_we;
                        addr_d  = ldr_addr;
                        wdata_d = ldr_wdata;
                    end else begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
                    wr_d    = we_d;
                    re_d    = ~we_d;
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d   = ACK;
                    cpu_ack_d = (owner_q == REQ_CPU);
                    ldr_ack_d = (owner_q == REQ_LDR);
                end else begin
                    state_d = WAIT;
                    cnt_d   = LAT_C;
                end
            end
            WAIT: begin
                if (cnt_q <= 3'd1) begin
                    state_d   = ACK;
                    cnt_d     = 3'd0;
                    cpu_ack_d = (owner_q == REQ_CPU);
                    ldr_ack_d = (owner_q == REQ_LDR);
                    if (owner_q == REQ_CPU) begin
                        cpu_rdata_d = Data_in_RAM;
                    end else begin
                        ldr_rdata_d = Data_in_RAM;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= REQ_CPU;
            owner_q     <= REQ_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 8'h00;
            cnt_q       <= 3'd0;
            re_q        <= 1'b0;
            wr_q        <= 1'b0;
            cpu_ack_q   <= 1'b0;
            ldr_ack_q   <= 1'b0;
            cpu_rdata_q <= 8'h00;
            ldr_rdata_q <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            re_q        <= re_d;
            wr_q        <= wr_d;
            cpu_ack_q   <= cpu_ack_d;
            ldr_ack_q   <= ldr_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_RE_RAM   = re_q;
    assign mem_WE_RAM   = wr_q;
    assign Data_Dir_RAM = addr_q;
    assign Data_RAM     = wdata_q;
    assign cpu_ack      = cpu_ack_q;
    assign ldr_ack      = ldr_ack_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign ldr_rdata    = ldr_rdata_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench: stimulus pushes expected strobes/acks, monitors pop and compare.
// RAM model returns addr[7:0] ^ 8'h2C after RD_LAT cycles.
module tb_ram_arbiter;

    typedef struct {
        bit          owner;
        bit          we;
        logic [31:0] addr;
        logic [7:0]  data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    exp_t sq[$];
    exp_t aq[$];
    exp_t aq4[$];

    // DUT with RD_LAT=1
    logic        rst, cpu_req, cpu_we, ldr_req, ldr_we;
    logic [31:0] cpu_addr, ldr_addr;
    logic [7:0]  cpu_wdata, ldr_wdata;
    logic        cpu_ack, ldr_ack, mem_RE_RAM, mem_WE_RAM, busy;
    logic [7:0]  cpu_rdata, ldr_rdata, Data_RAM;
    logic [31:0] Data_Dir_RAM;
    logic [7:0]  Data_in_RAM;

    // DUT with RD_LAT=4
    logic        b_rst, b_cpu_req, b_cpu_we, b_ldr_req, b_ldr_we;
    logic [31:0] b_cpu_addr, b_ldr_addr;
    logic [7:0]  b_cpu_wdata, b_ldr_wdata;
    logic        b_cpu_ack, b_ldr_ack, b_re, b_we, b_busy;
    logic [7:0]  b_cpu_rdata, b_ldr_rdata, b_data;
    logic [31:0] b_dir;
    logic [7:0]  b_pipe [4];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ram_arbiter #(.RD_LAT(1), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .mem_RE_RAM(mem_RE_RAM), .mem_WE_RAM(mem_WE_RAM),
        .Data_Dir_RAM(Data_Dir_RAM), .Data_RAM(Data_RAM), .Data_in_RAM(Data_in_RAM),
        .busy(busy)
    );

    ram_arbiter #(.RD_LAT(4), .ADDR_W(32)) dut4 (
        .clk(clk), .rst(b_rst),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
        .ldr_req(b_ldr_req), .ldr_we(b_ldr_we), .ldr_addr(b_ldr_addr), .ldr_wdata(b_ldr_wdata),
        .ldr_ack(b_ldr_ack), .ldr_rdata(b_ldr_rdata),
        .mem_RE_RAM(b_re), .mem_WE_RAM(b_we),
        .Data_Dir_RAM(b_dir), .Data_RAM(b_data), .Data_in_RAM(b_pipe[3]),
        .busy(b_busy)
    );

    // RAM models: data appears exactly RD_LAT edges after the strobe edge, zero otherwise.
    always @(posedge clk) begin
        Data_in_RAM <= (mem_RE_RAM === 1'b1) ? (Data_Dir_RAM[7:0] ^ 8'h2C) : 8'h00;
        b_pipe[0]   <= (b_re === 1'b1) ? (b_dir[7:0] ^ 8'h2C) : 8'h00;
        b_pipe[1]   <= b_pipe[0];
        b_pipe[2]   <= b_pipe[1];
        b_pipe[3]   <= b_pipe[2];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cyc %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic exp_strobe(input bit owner, input bit we, input logic [31:0] a,
                              input logic [7:0] d, input int s);
        exp_t e;
        e.owner = owner; e.we = we; e.addr = a; e.data = d; e.cyc = s;
        sq.push_back(e);
    endtask

    // s = cycle of the sampling edge, n = cycles from that edge to the ack cycle
    task automatic exp_txn(input bit owner, input bit we, input logic [31:0] a,
                           input logic [7:0] d, input int s, input int n);
        exp_t e;
        exp_strobe(owner, we, a, d, s);
        e.owner = owner; e.we = we; e.addr = a; e.data = d; e.cyc = s + n - 1;
        aq.push_back(e);
    endtask

    task automatic drive_cpu(input bit req, input bit we, input logic [31:0] a, input logic [7:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic drive_ldr(input bit req, input bit we, input logic [31:0] a, input logic [7:0] d);
        ldr_req = req; ldr_we = we; ldr_addr = a; ldr_wdata = d;
    endtask

    // Monitor for the RD_LAT=1 instance
    initial begin
        exp_t ms, ma;
        forever begin
            @(negedge clk);
            if (mem_WE_RAM === 1'b1 || mem_RE_RAM === 1'b1) begin
                if (sq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL strobe_unexpected actual=re%0b/we%0b required=none (cyc %0d)",
                             mem_RE_RAM, mem_WE_RAM, cyc);
                end else begin
                    ms = sq.pop_front();
                    chk("strobe_we", 32'(mem_WE_RAM), 32'(ms.we));
                    chk("strobe_re", 32'(mem_RE_RAM), 32'(!ms.we));
                    chk("strobe_cyc", cyc, ms.cyc);
                    chk("strobe_addr", Data_Dir_RAM, ms.addr);
                    if (ms.we) chk("strobe_data", 32'(Data_RAM), 32'(ms.data));
                end
            end
            if (cpu_ack === 1'b1 || ldr_ack === 1'b1) begin
                if (aq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ack_unexpected actual=cpu%0b/ldr%0b required=none (cyc %0d)",
                             cpu_ack, ldr_ack, cyc);
                end else begin
                    ma = aq.pop_front();
                    chk("ack_cpu", 32'(cpu_ack), 32'(!ma.owner));
                    chk("ack_ldr", 32'(ldr_ack), 32'(ma.owner));
                    chk("ack_cyc", cyc, ma.cyc);
                    if (!ma.we) begin
                        if (ma.owner) chk("ldr_rdata", 32'(ldr_rdata), 32'(ma.data));
                        else          chk("cpu_rdata", 32'(cpu_rdata), 32'(ma.data));
                    end
                end
            end
        end
    end

    // Monitor for the RD_LAT=4 instance
    initial begin
        exp_t mb;
        forever begin
            @(negedge clk);
            if (b_cpu_ack === 1'b1 || b_ldr_ack === 1'b1) begin
                if (aq4.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL lat4_ack_unexpected actual=1 required=0 (cyc %0d)", cyc);
                end else begin
                    mb = aq4.pop_front();
                    chk("lat4_ack_cpu", 32'(b_cpu_ack), 32'(!mb.owner));
                    chk("lat4_ack_cyc", cyc, mb.cyc);
                    chk("lat4_rdata", 32'(b_cpu_rdata), 32'(mb.data));
                end
            end
        end
    end

    initial begin
        int   c;
        int   bcnt, recnt, recyc, ackcyc;
        exp_t e4;
        rst = 1'b1; b_rst = 1'b1;
        drive_cpu(1'b0, 1'b0, 32'h0, 8'h00);
        drive_ldr(1'b0, 1'b0, 32'h0, 8'h00);
        b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = 32'h0; b_cpu_wdata = 8'h00;
        b_ldr_req = 1'b0; b_ldr_we = 1'b0; b_ldr_addr = 32'h0; b_ldr_wdata = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_ldr_ack", 32'(ldr_ack), 32'd0);
        chk("rst_re", 32'(mem_RE_RAM), 32'd0);
        chk("rst_we", 32'(mem_WE_RAM), 32'd0);
        chk("rst_dir", Data_Dir_RAM, 32'd0);
        chk("rst_data", 32'(Data_RAM), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_ldr_rdata", 32'(ldr_rdata), 32'd0);
        chk("rst_lat4_busy", 32'(b_busy), 32'd0);
        rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);

        // CPU write 0x10 <- 0xA5: ack 2 cycles after sampling edge
        c = cyc;
        drive_cpu(1'b1, 1'b1, 32'h10, 8'hA5);
        exp_txn(1'b0, 1'b1, 32'h10, 8'hA5, c + 1, 2);
        repeat (2) @(negedge clk);
        chk("wr_busy_ack", 32'(busy), 32'd1);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("wr_busy_idle", 32'(busy), 32'd0);

        // CPU read 0x10 -> 0x3C: ack 3 cycles after sampling edge
        c = cyc;
        drive_cpu(1'b1, 1'b0, 32'h10, 8'h00);
        exp_txn(1'b0, 1'b0, 32'h10, 8'h3C, c + 1, 3);
        repeat (3) @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rdata_hold", 32'(cpu_rdata), 32'h3C);

        // Tie after reset: cpu, then cpu re-requests -> second tie goes to ldr, then cpu
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        c = cyc;
        drive_cpu(1'b1, 1'b1, 32'h20, 8'h11);
        drive_ldr(1'b1, 1'b0, 32'h30, 8'h00);
        exp_txn(1'b0, 1'b1, 32'h20, 8'h11, c + 1, 2);
        exp_txn(1'b1, 1'b0, 32'h30, 8'h1C, c + 4, 3);
        exp_txn(1'b0, 1'b1, 32'h20, 8'h11, c + 8, 2);
        repeat (6) @(negedge clk);
        ldr_req = 1'b0;
        repeat (3) @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);

        // Loader held high: back-to-back writes with one IDLE cycle after each ack
        c = cyc;
        drive_ldr(1'b1, 1'b1, 32'h40, 8'h5A);
        exp_txn(1'b1, 1'b1, 32'h40, 8'h5A, c + 1, 2);
        exp_txn(1'b1, 1'b1, 32'h40, 8'h5A, c + 4, 2);
        exp_txn(1'b1, 1'b1, 32'h40, 8'h5A, c + 7, 2);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("b2b_busy", 32'(busy), 32'((k % 3) != 0));
        end
        ldr_req = 1'b0;
        @(negedge clk);
        chk("b2b_busy_end", 32'(busy), 32'd0);

        // Reset during WAIT of a read: no ack, strobes low, next tie grants cpu
        c = cyc;
        drive_cpu(1'b1, 1'b0, 32'h50, 8'h00);
        exp_strobe(1'b0, 1'b0, 32'h50, 8'h00, c + 1);
        repeat (2) @(negedge clk);
        chk("abort_busy_wait", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_re", 32'(mem_RE_RAM), 32'd0);
        chk("abort_we", 32'(mem_WE_RAM), 32'd0);
        chk("abort_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("abort_dir", Data_Dir_RAM, 32'd0);
        drive_cpu(1'b1, 1'b0, 32'h50, 8'h00);
        drive_ldr(1'b1, 1'b1, 32'h60, 8'h33);
        exp_txn(1'b0, 1'b0, 32'h50, 8'h7C, c + 4, 3);
        exp_txn(1'b1, 1'b1, 32'h60, 8'h33, c + 8, 2);
        repeat (3) @(negedge clk);
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        ldr_req = 1'b0;
        @(negedge clk);

        // RD_LAT=4 read of 0x70 -> 0x5C on the second instance
        c = cyc;
        b_cpu_req = 1'b1; b_cpu_we = 1'b0; b_cpu_addr = 32'h70;
        e4.owner = 1'b0; e4.we = 1'b0; e4.addr = 32'h70; e4.data = 8'h5C; e4.cyc = c + 6;
        aq4.push_back(e4);
        bcnt = 0; recnt = 0; recyc = -100; ackcyc = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (b_busy === 1'b1) bcnt++;
            if (b_re === 1'b1) begin recnt++; recyc = cyc; end
            if (b_cpu_ack === 1'b1) ackcyc = cyc;
            if (cyc == c + 6) b_cpu_req = 1'b0;
        end
        chk("lat4_busy_cycles", bcnt, 32'd6);
        chk("lat4_re_pulses", recnt, 32'd1);
        chk("lat4_wait_cycles", ackcyc - recyc - 1, 32'd4);

        repeat (2) @(negedge clk);
        chk("sb_strobes_left", sq.size(), 32'd0);
        chk("sb_acks_left", aq.size(), 32'd0);
        chk("sb_lat4_left", aq4.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter RD_LAT, default 1, giving RAM read latency in cycles after the read-strobe cycle; legal range 1..7.
REQ-002 The block SHALL have parameter ADDR_W, default 32, giving the RAM address width.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high. Ports are as follows.
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
cpu_req  in  1  processor access request, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
cpu_addr  in  ADDR_W  processor address
cpu_wdata  in  8  processor write byte
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  8  read byte, valid while cpu_ack is high
ldr_req  in  1  loader/DMA request, same rules as cpu_req
ldr_we  in  1  loader write enable
ldr_addr  in  ADDR_W  loader address
ldr_wdata  in  8  loader write byte
ldr_ack  out  1  loader completion pulse
ldr_rdata  out  8  loader read byte, valid while ldr_ack is high
mem_RE_RAM  out  1  RAM read strobe
mem_WE_RAM  out  1  RAM write strobe
Data_Dir_RAM  out  ADDR_W  RAM address
Data_RAM  out  8  RAM write data
Data_in_RAM  in  8  RAM read data
busy  out  1  high in any state other than IDLE

Function
REQ-004 The FSM SHALL have the states IDLE, ACCESS, WAIT and ACK, and SHALL change state only on clk rising edges.
REQ-005 In IDLE, with one or more req inputs high at a clock edge, the block SHALL latch the winner's we, addr and wdata, and SHALL go to ACCESS.
REQ-006 Arbitration SHALL be round-robin between the two requesters: a one-bit pointer selects the requester that wins a tie, and it SHALL point to the non-winner after each grant.
REQ-007 When only one req input is high, that requester SHALL win regardless of the pointer.
REQ-008 In ACCESS, which lasts exactly 1 cycle, the block SHALL drive Data_Dir_RAM and Data_RAM from the latched values.
- If the latched we is 1, it SHALL assert mem_WE_RAM and go to ACK.
- If the latched we is 0, it SHALL assert mem_RE_RAM and go to WAIT.
REQ-009 WAIT SHALL last exactly RD_LAT cycles, counted by a 3-bit down-counter; Data_in_RAM SHALL be registered at the edge that ends the last WAIT cycle.
REQ-010 ACK SHALL last 1 cycle and SHALL pulse only the winner's ack; the winner's rdata SHALL carry the registered byte for reads. The FSM then returns to IDLE.
REQ-011 Latency from the req-sampling edge to the ack cycle SHALL be 2 cycles for a write and 2+RD_LAT cycles for a read.
REQ-012 mem_RE_RAM and mem_WE_RAM SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per transaction.
REQ-013 A req input still high in the IDLE cycle after its ack SHALL be treated as a new transaction; requesters drop req on the edge that samples ack.
REQ-014 A req input of the non-winner that rises or falls during a transaction SHALL be ignored until IDLE.
REQ-015 Between transactions, Data_Dir_RAM, Data_RAM and both rdata outputs SHALL hold their last values.
REQ-016 Address and data SHALL pass through without width change or arithmetic.

Reset
REQ-017 While rst is high at an edge, the block SHALL:
- set state to IDLE;
- set the pointer to cpu;
- clear the WAIT counter;
- drive cpu_ack, ldr_ack, mem_RE_RAM, mem_WE_RAM and busy to 0;
- drive Data_Dir_RAM, Data_RAM, cpu_rdata and ldr_rdata to 0.
REQ-018 A reset in any non-IDLE state SHALL abort the transaction with no ack; the requester SHALL re-issue its request after reset.
REQ-019 Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-020 A shared package ram_arb_pkg SHALL hold:
- the state enum (IDLE, ACCESS, WAIT, ACK);
- requester IDs REQ_CPU=0 and REQ_LDR=1;
- the RD_LAT maximum constant 7.
REQ-021 The block SHALL be a single module with no sub-module; the pointer, counter and FSM are small enough to inline.

Verification
REQ-022 The bench SHALL cover these directed scenarios.
- CPU write only: addr=0x10, wdata=0xA5 -> mem_WE_RAM high for 1 cycle with Data_Dir_RAM=0x10 and Data_RAM=0xA5; cpu_ack 2 cycles after the sampling edge; ldr_ack stays 0.
- CPU read with RD_LAT=1 and RAM model returning 0x3C for addr=0x10 -> mem_RE_RAM high for 1 cycle; cpu_ack with cpu_rdata=0x3C 3 cycles after the sampling edge.
- cpu_req and ldr_req rise in the same cycle after reset -> cpu is served first and ldr second; a second tie is served ldr first.
- ldr_req held high continuously with cpu_req idle -> back-to-back ldr transactions, each ldr_ack followed by one IDLE cycle.
- rst pulsed in the WAIT cycle of a read -> no ack; all strobes 0 on the next cycle; busy=0; the next tie grants cpu.
- RD_LAT=4 read -> exactly 4 WAIT cycles between mem_RE_RAM and the ack cycle; busy is high for 6 cycles.
